// File: rtl/flow_dep_join.sv
`default_nettype none
// ============================================================================
// Module      : flow_dep_join
// Description : Dependency-join stage of the batch-flow task graph. Collects
//               one done token (with file-tag) from every enabled predecessor,
//               then issues a single start token carrying all collected tags
//               to the dependent cell. Also covers order-only dependencies.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_dep_join #(
    parameter int NUM_PRED    = 4,
    parameter int TAG_W       = 16,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PRED-1:0]       cfg_mask_i,
    input  logic [NUM_PRED-1:0]       done_valid_i,
    input  logic [NUM_PRED*TAG_W-1:0] done_tag_i,
    output logic [NUM_PRED-1:0]       done_ready_o,
    output logic                      start_valid_o,
    output logic [NUM_PRED*TAG_W-1:0] start_tags_o,
    input  logic                      start_ready_i,
    output logic [CNT_W-1:0]          batch_cnt_o,
    output logic                      stall_irq_o,
    output logic                      cfg_err_o
);

    localparam logic [0:0] c_COLLECT = 1'b0;
    localparam logic [0:0] c_FIRE    = 1'b1;

    logic [0:0]                state_q,    state_d;
    logic [NUM_PRED-1:0]       got_q,      got_d;
    logic [NUM_PRED-1:0]       mask_q,     mask_d;
    logic                      mask_vld_q, mask_vld_d;
    logic [NUM_PRED*TAG_W-1:0] tags_q,     tags_d;
    logic [CNT_W-1:0]          cnt_q,      cnt_d;

    logic [NUM_PRED-1:0]       w_hs;
    logic [NUM_PRED-1:0]       w_got_hs;
    logic                      w_all_in;

    // Accept tokens only while collecting, only on enabled channels not yet seen
    always_comb begin
        done_ready_o = '0;
        if (state_q == c_COLLECT) begin
            done_ready_o = mask_q & ~got_q;
        end
    end

    // Handshakes this cycle and whether they complete the join
    always_comb begin
        w_hs     = done_valid_i & done_ready_o;
        w_got_hs = got_q | w_hs;
        w_all_in = (mask_q != '0) && ((w_got_hs & mask_q) == mask_q);
    end

    // Join state machine: collect tokens, then hold start until accepted
    always_comb begin
        state_d    = state_q;
        got_d      = got_q;
        mask_d     = mask_q;
        mask_vld_d = mask_vld_q;
        tags_d     = tags_q;
        cnt_d      = cnt_q;
        case (state_q)
            c_COLLECT: begin
                // Mask is only sampled between batches so a running join
                // keeps the predecessor set it started with.
                if (got_q == '0) begin
                    mask_d     = cfg_mask_i;
                    mask_vld_d = 1'b1;
                end
                got_d = w_got_hs;
                for (int i = 0; i < NUM_PRED; i++) begin
                    if (w_hs[i]) begin
                        tags_d[i*TAG_W +: TAG_W] = done_tag_i[i*TAG_W +: TAG_W];
                    end
                end
                if (w_all_in) begin
                    state_d = c_FIRE;
                end
            end
            c_FIRE: begin
                if (start_ready_i) begin
                    got_d   = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = c_COLLECT;
                end
            end
            default: begin
                state_d = c_COLLECT;
            end
        endcase
    end

    // Join state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_COLLECT;
            got_q      <= '0;
            mask_q     <= '0;
            mask_vld_q <= 1'b0;
            tags_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            got_q      <= got_d;
            mask_q     <= mask_d;
            mask_vld_q <= mask_vld_d;
            tags_q     <= tags_d;
            cnt_q      <= cnt_d;
        end
    end

    assign start_valid_o = (state_q == c_FIRE);
    assign batch_cnt_o   = cnt_q;
    // The reset value of mask_q is not a real configuration, so the error
    // flag only reports once a mask has actually been sampled.
    assign cfg_err_o     = mask_vld_q & (mask_q == '0);

    // Disabled slots always present zero to the dependent cell
    genvar g;
    generate
        for (g = 0; g < NUM_PRED; g++) begin : g_slot
            assign start_tags_o[g*TAG_W +: TAG_W] =
                mask_q[g] ? tags_q[g*TAG_W +: TAG_W] : '0;
        end
    endgenerate

    generate
        if (TIMEOUT_CYC > 0) begin : g_stall
            localparam int c_STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
            localparam logic [c_STALL_W-1:0] c_TIMEOUT = c_STALL_W'(TIMEOUT_CYC);

            logic [c_STALL_W-1:0] stall_q, stall_d;
            logic                 irq_q,   irq_d;

            // Partial-join watchdog: counts idle cycles, saturates, fires once
            always_comb begin
                stall_d = stall_q;
                if ((state_q != c_COLLECT) || (got_q == '0) || (w_hs != '0)) begin
                    stall_d = '0;
                end else if (stall_q != c_TIMEOUT) begin
                    stall_d = stall_q + c_STALL_W'(1);
                end
                irq_d = (stall_d == c_TIMEOUT) && (stall_q != c_TIMEOUT);
            end

            // Watchdog registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stall_q <= '0;
                    irq_q   <= 1'b0;
                end else begin
                    stall_q <= stall_d;
                    irq_q   <= irq_d;
                end
            end

            assign stall_irq_o = irq_q;
        end else begin : g_no_stall
            assign stall_irq_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_flow_dep_join.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_dep_join
// Description : Directed self-checking bench for flow_dep_join with a start
//               token scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_dep_join;

    localparam int NP = 4;
    localparam int TW = 16;
    localparam int CW = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NP-1:0]  cfg_mask;
    logic [NP-1:0]  done_valid;
    logic [NP*TW-1:0] done_tag;
    logic [NP-1:0]  done_ready;
    logic           start_valid;
    logic [NP*TW-1:0] start_tags;
    logic           start_ready;
    logic [CW-1:0]  batch_cnt;
    logic           stall_irq;
    logic           cfg_err;

    int tests = 0;
    int fails = 0;
    logic [NP*TW-1:0] exp_q[$];
    logic [CW-1:0]    exp_cnt;

    flow_dep_join #(
        .NUM_PRED   (NP),
        .TAG_W      (TW),
        .CNT_W      (CW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_mask_i   (cfg_mask),
        .done_valid_i (done_valid),
        .done_tag_i   (done_tag),
        .done_ready_o (done_ready),
        .start_valid_o(start_valid),
        .start_tags_o (start_tags),
        .start_ready_i(start_ready),
        .batch_cnt_o  (batch_cnt),
        .stall_irq_o  (stall_irq),
        .cfg_err_o    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted start token must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && start_valid && start_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_start observed=%h expected=none", start_tags);
            end else begin
                check("start_tags", start_tags, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_mask = '0; done_valid = '0; done_tag = '0; start_ready = 1'b0;
        exp_cnt = '0;
        #2;
        check("rst_start_valid", start_valid, 0);
        check("rst_done_ready", done_ready, 0);
        check("rst_cnt", batch_cnt, 0);
        check("rst_irq", stall_irq, 0);
        check("rst_cfg_err", cfg_err, 0);
        step(); step();
        rst = 1'b0;

        // 1: two-input join, tokens at different times
        cfg_mask = 4'b0011; start_ready = 1'b1;
        step();
        done_valid = 4'b0001; done_tag[15:0] = 16'h00A1;
        check("t1_ready", done_ready, 4'b0011);
        step();
        done_valid = '0;
        check("t1_ready_after0", done_ready, 4'b0010);
        step(); step();
        done_valid = 4'b0010; done_tag[31:16] = 16'h00B2;
        exp_q.push_back({16'h0, 16'h0, 16'h00B2, 16'h00A1});
        check("t1_no_start_yet", start_valid, 0);
        step();
        done_valid = '0;
        check("t1_start_valid", start_valid, 1);
        check("t1_fire_ready", done_ready, 0);
        step();
        exp_cnt++;
        check("t1_cnt", batch_cnt, exp_cnt);
        check("t1_start_drop", start_valid, 0);

        // 2: four tokens together, dependent cell back-pressures
        cfg_mask = 4'b1111; start_ready = 1'b0;
        step();
        done_valid = 4'b1111;
        done_tag = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        exp_q.push_back({16'h4444, 16'h3333, 16'h2222, 16'h1111});
        step();
        done_valid = '0;
        done_tag = '0;
        for (int k = 1; k <= 5; k++) begin
            check("t2_start_valid", start_valid, 1);
            check("t2_ready_zero", done_ready, 0);
            check("t2_tags_stable", start_tags, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
            check("t2_cnt_hold", batch_cnt, exp_cnt);
            if (k == 5) start_ready = 1'b1;
            step();
        end
        exp_cnt++;
        check("t2_cnt", batch_cnt, exp_cnt);

        // 3: order-only dependency, disabled channel ignored, then timeout
        cfg_mask = 4'b0001;
        step();
        done_valid = 4'b0010; done_tag[31:16] = 16'hBEEF;
        for (int k = 0; k < 12; k++) begin
            step();
            check("t3_no_irq", stall_irq, 0);
            check("t3_no_start", start_valid, 0);
        end
        done_valid = '0;
        cfg_mask = 4'b0011;
        step();
        done_valid = 4'b0001; done_tag[15:0] = 16'h0C0C;
        step();
        done_valid = '0;
        check("t3_waiting", done_ready, 4'b0010);
        for (int k = 1; k <= 20; k++) begin
            step();
            check("t3_irq_pulse", stall_irq, (k == TO) ? 1 : 0);
        end
        done_valid = 4'b0010; done_tag[31:16] = 16'h0D0D;
        exp_q.push_back({16'h0, 16'h0, 16'h0D0D, 16'h0C0C});
        step();
        done_valid = '0;
        check("t3_start", start_valid, 1);
        step();
        exp_cnt++;
        check("t3_cnt", batch_cnt, exp_cnt);

        // 4: mask change mid-batch applies only to the next batch
        step();
        done_valid = 4'b0001; done_tag[15:0] = 16'h0E01;
        step();
        done_valid = '0;
        cfg_mask = 4'b0001;
        step(); step();
        check("t4_still_wait", done_ready, 4'b0010);
        check("t4_no_start", start_valid, 0);
        done_valid = 4'b0010; done_tag[31:16] = 16'h0E02;
        exp_q.push_back({16'h0, 16'h0, 16'h0E02, 16'h0E01});
        step();
        done_valid = '0;
        step();
        exp_cnt++;
        check("t4_cnt", batch_cnt, exp_cnt);
        step();
        check("t4_new_mask", done_ready, 4'b0001);
        done_valid = 4'b0001; done_tag[15:0] = 16'h0E03;
        exp_q.push_back({16'h0, 16'h0, 16'h0, 16'h0E03});
        step();
        done_valid = '0;
        step();
        exp_cnt++;
        check("t4_cnt2", batch_cnt, exp_cnt);

        // 5: asynchronous reset while a start token is held
        cfg_mask = 4'b0011; start_ready = 1'b0;
        step();
        done_valid = 4'b0011; done_tag[31:0] = {16'h5B5B, 16'h5A5A};
        step();
        done_valid = '0;
        check("t5_fire", start_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_drop", start_valid, 0);
        check("t5_cnt_clr", batch_cnt, 0);
        exp_cnt = '0;
        step();
        rst = 1'b0;
        start_ready = 1'b1;
        step();
        done_valid = 4'b0011; done_tag[31:0] = {16'h6262, 16'h6161};
        exp_q.push_back({16'h0, 16'h0, 16'h6262, 16'h6161});
        step();
        done_valid = '0;
        step();
        exp_cnt++;
        check("t5_cnt", batch_cnt, exp_cnt);

        // 6: counter wrap over consecutive single-input joins, then empty mask
        cfg_mask = 4'b0001;
        step();
        for (int j = 0; j < 15; j++) begin
            done_valid = 4'b0001; done_tag[15:0] = 16'h7000 + 16'(j);
            exp_q.push_back({48'h0, 16'h7000 + 16'(j)});
            step();
            done_valid = '0;
            step();
            exp_cnt++;
            check("t6_cnt", batch_cnt, exp_cnt);
        end
        check("t6_wrap", batch_cnt, 4'd0);
        cfg_mask = 4'b0000;
        step(); step();
        check("t6_cfg_err", cfg_err, 1);
        done_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_no_start", start_valid, 0);
            check("t6_no_ready", done_ready, 0);
        end
        done_valid = '0;
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
